// File: rtl/fas_pkg.sv
// rtl/fas_pkg.sv - shared types, constants and magnitude helper for the FAS FFT reader
package fas_pkg;

   localparam int FAS_DW = 16;
   localparam int NPT    = 16;
   localparam int IDXW   = 4;

   typedef struct packed {
      logic signed [FAS_DW-1:0] re;
      logic signed [FAS_DW-1:0] im;
   } point_t;

   typedef enum logic {IDLE, DRAIN} state_e;

   // |re|+|im| widened by one bit so that |-2^(DW-1)| is represented exactly
   function automatic logic [FAS_DW:0] abs_mag(input logic [FAS_DW-1:0] re,
                                               input logic [FAS_DW-1:0] im);
      logic [FAS_DW:0] ar;
      logic [FAS_DW:0] ai;
      ar = re[FAS_DW-1] ? ({1'b0, ~re} + (FAS_DW+1)'(1)) : {1'b0, re};
      ai = im[FAS_DW-1] ? ({1'b0, ~im} + (FAS_DW+1)'(1)) : {1'b0, im};
      return ar + ai;
   endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// rtl/fft_frame_bank.sv - one 16-point frame register bank with parallel load and indexed read
module fft_frame_bank
   import fas_pkg::*;
#(
   parameter int DW = FAS_DW
) (
   input  logic                          clk,
   input  logic                          load,
   input  logic [NPT-1:0][2*DW-1:0]      din,
   input  logic [IDXW-1:0]               rd_idx,
   output logic [2*DW-1:0]               rd_data
);

   logic [NPT-1:0][2*DW-1:0] mem_q;
   logic [NPT-1:0][2*DW-1:0] mem_d;

   // whole frame is replaced in one cycle when load is asserted
   always_comb begin
      mem_d = mem_q;
      if (load) mem_d = din;
   end

   // data store carries no reset; validity is tracked by the owner's full flags
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/fft_point_serializer.sv
// rtl/fft_point_serializer.sv - ping-pong buffered serializer of 16-point FFT frames with peak-bin search
module fft_point_serializer
   import fas_pkg::*;
#(
   parameter int DW    = FAS_DW,
   parameter int DROPW = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fft_valid,
   input  logic [2*DW-1:0]    fft_d0,
   input  logic [2*DW-1:0]    fft_d1,
   input  logic [2*DW-1:0]    fft_d2,
   input  logic [2*DW-1:0]    fft_d3,
   input  logic [2*DW-1:0]    fft_d4,
   input  logic [2*DW-1:0]    fft_d5,
   input  logic [2*DW-1:0]    fft_d6,
   input  logic [2*DW-1:0]    fft_d7,
   input  logic [2*DW-1:0]    fft_d8,
   input  logic [2*DW-1:0]    fft_d9,
   input  logic [2*DW-1:0]    fft_d10,
   input  logic [2*DW-1:0]    fft_d11,
   input  logic [2*DW-1:0]    fft_d12,
   input  logic [2*DW-1:0]    fft_d13,
   input  logic [2*DW-1:0]    fft_d14,
   input  logic [2*DW-1:0]    fft_d15,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*DW-1:0]    out_data,
   output logic [IDXW-1:0]    out_idx,
   output logic               out_last,
   output logic               peak_valid,
   output logic [IDXW-1:0]    peak_idx,
   output logic               overflow,
   output logic [DROPW-1:0]   drop_cnt
);

   logic [NPT-1:0][2*DW-1:0] frame_in;
   assign frame_in = {fft_d15, fft_d14, fft_d13, fft_d12, fft_d11, fft_d10, fft_d9, fft_d8,
                      fft_d7, fft_d6, fft_d5, fft_d4, fft_d3, fft_d2, fft_d1, fft_d0};

   state_e            state_q, state_d;
   logic [1:0]        full_q, full_d;
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic [DW:0]       max_q, max_d;
   logic [IDXW-1:0]   max_idx_q, max_idx_d;
   logic [IDXW-1:0]   peak_idx_q, peak_idx_d;
   logic              peak_valid_q, peak_valid_d;
   logic              overflow_q, overflow_d;
   logic [DROPW-1:0]  drop_cnt_q, drop_cnt_d;

   logic [1:0]        load;
   logic [1:0]        freed;
   logic [2*DW-1:0]   rd_data0, rd_data1, rd_data;
   logic              xfer, last_xfer, capture, drop, beats_max;
   logic [DW:0]       cur_mag;
   point_t            cur_pt;

   fft_frame_bank #(.DW(DW)) u_bank0 (
      .clk(clk), .load(load[0]), .din(frame_in), .rd_idx(idx_q), .rd_data(rd_data0)
   );

   fft_frame_bank #(.DW(DW)) u_bank1 (
      .clk(clk), .load(load[1]), .din(frame_in), .rd_idx(idx_q), .rd_data(rd_data1)
   );

   assign rd_data    = rd_ptr_q ? rd_data1 : rd_data0;
   assign out_valid  = (state_q == DRAIN);
   assign out_data   = out_valid ? rd_data : '0;
   assign out_idx    = idx_q;
   assign out_last   = out_valid && (idx_q == IDXW'(NPT-1));
   assign peak_valid = peak_valid_q;
   assign peak_idx   = peak_idx_q;
   assign overflow   = overflow_q;
   assign drop_cnt   = drop_cnt_q;
   assign cur_pt     = point_t'(rd_data);
   assign cur_mag    = abs_mag(cur_pt.re, cur_pt.im);

   // bank bookkeeping, drain sequencing and peak tracking; a bank freed this cycle may be refilled at once
   always_comb begin
      xfer      = out_valid && out_ready;
      last_xfer = xfer && (idx_q == IDXW'(NPT-1));
      freed     = full_q;
      if (last_xfer) freed[rd_ptr_q] = 1'b0;
      capture   = fft_valid && !freed[wr_ptr_q];
      drop      = fft_valid && freed[wr_ptr_q];
      load      = 2'b00;
      if (capture) load[wr_ptr_q] = 1'b1;
      full_d    = freed | load;
      wr_ptr_d  = wr_ptr_q ^ capture;

      overflow_d = overflow_q | drop;
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROPW'(1);

      state_d  = state_q;
      idx_d    = idx_q;
      rd_ptr_d = rd_ptr_q;
      case (state_q)
         IDLE: if (full_q[rd_ptr_q]) state_d = DRAIN;
         DRAIN: begin
            if (last_xfer) begin
               idx_d    = '0;
               rd_ptr_d = ~rd_ptr_q;
               if (!full_d[~rd_ptr_q]) state_d = IDLE;
            end else if (xfer) begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // strict compare keeps the lower index on ties; bin 0 always seeds the search
      beats_max    = (idx_q == '0) || (cur_mag > max_q);
      max_d        = max_q;
      max_idx_d    = max_idx_q;
      peak_idx_d   = peak_idx_q;
      peak_valid_d = 1'b0;
      if (xfer && beats_max) begin
         max_d     = cur_mag;
         max_idx_d = idx_q;
      end
      if (last_xfer) begin
         peak_valid_d = 1'b1;
         peak_idx_d   = beats_max ? idx_q : max_idx_q;
      end
   end

   // state registers; reset abandons any drain in progress and empties both banks
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         full_q       <= 2'b00;
         wr_ptr_q     <= 1'b0;
         rd_ptr_q     <= 1'b0;
         idx_q        <= '0;
         max_q        <= '0;
         max_idx_q    <= '0;
         peak_idx_q   <= '0;
         peak_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         full_q       <= full_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         idx_q        <= idx_d;
         max_q        <= max_d;
         max_idx_q    <= max_idx_d;
         peak_idx_q   <= peak_idx_d;
         peak_valid_q <= peak_valid_d;
         overflow_q   <= overflow_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

endmodule
